// File: rtl/wb_seq_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command port.
// Optional ack timeout abort is enabled by defining WBM_TIMEOUT_EN.
module wb_seq_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [DATA_W-1:0]   wbm_dat_i
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                cmd_ready_r, cmd_ready_s;
    logic                cyc_r, cyc_s;
    logic                we_r, we_s;
    logic [SEL_W-1:0]    sel_r, sel_s;
    logic [ADDR_W-1:0]   adr_r, adr_s;
    logic [DATA_W-1:0]   dat_r, dat_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic [DATA_W-1:0]   rsp_dat_r, rsp_dat_s;
    logic                rsp_err_r, rsp_err_s;

`ifdef WBM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_r, cnt_s;
`endif

    // State and registered bus/response outputs; reset drops CYC/STB asynchronously.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= {SEL_W{1'b0}};
            adr_r       <= {ADDR_W{1'b0}};
            dat_r       <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            cnt_r       <= {CNT_W{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            cyc_r       <= cyc_s;
            we_r        <= we_s;
            sel_r       <= sel_s;
            adr_r       <= adr_s;
            dat_r       <= dat_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_dat_r   <= rsp_dat_s;
            rsp_err_r   <= rsp_err_s;
`ifdef WBM_TIMEOUT_EN
            cnt_r       <= cnt_s;
`endif
        end
    end

    // Next-state and next-output decode for the IDLE/BUS/RESP sequencer.
    always_comb begin
        state_s     = state_r;
        cyc_s       = cyc_r;
        we_s        = we_r;
        sel_s       = sel_r;
        adr_s       = adr_r;
        dat_s       = dat_r;
        rsp_valid_s = rsp_valid_r;
        rsp_dat_s   = rsp_dat_r;
        rsp_err_s   = rsp_err_r;
`ifdef WBM_TIMEOUT_EN
        cnt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cyc_s   = 1'b1;
                    we_s    = cmd_we;
                    sel_s   = cmd_sel;
                    adr_s   = cmd_adr;
                    dat_s   = cmd_dat;
                    state_s = ST_BUS;
`ifdef WBM_TIMEOUT_EN
                    cnt_s   = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    cyc_s       = 1'b0;
                    we_s        = 1'b0;
                    sel_s       = {SEL_W{1'b0}};
                    rsp_valid_s = 1'b1;
                    rsp_dat_s   = we_r ? {DATA_W{1'b0}} : wbm_dat_i;
                    rsp_err_s   = 1'b0;
                    state_s     = ST_RESP;
                end else begin
`ifdef WBM_TIMEOUT_EN
                    // Abort on the edge that completes the TIMEOUT_CYCLES-th STB cycle.
                    if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cyc_s       = 1'b0;
                        we_s        = 1'b0;
                        sel_s       = {SEL_W{1'b0}};
                        rsp_valid_s = 1'b1;
                        rsp_dat_s   = {DATA_W{1'b0}};
                        rsp_err_s   = 1'b1;
                        state_s     = ST_RESP;
                    end else if (cnt_r != {CNT_W{1'b1}}) begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
`else
                    state_s = ST_BUS;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
`ifdef WBM_TIMEOUT_EN
                    cnt_s       = {CNT_W{1'b0}};
`endif
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                cyc_s       = 1'b0;
                rsp_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
        cmd_ready_s = (state_s == ST_IDLE);
    end

    assign cmd_ready = cmd_ready_r;
    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = cyc_r;
    assign wbm_we_o  = we_r;
    assign wbm_sel_o = sel_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dat   = rsp_dat_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed self-checking bench for wb_seq_master; the timeout scenario follows WBM_TIMEOUT_EN.
module tb_wb_seq_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    int tests_run = 0;
    int tests_failed = 0;

    wb_seq_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    endtask

    task automatic test_reset;
        wb_rst_ni = 1'b0; rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        repeat (3) tick();
        tests_run++;
        if (cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: ready=%b cyc=%b stb=%b, want 1 0 0", cmd_ready, wbm_cyc_o, wbm_stb_o);
        end
        tests_run++;
        if ({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 69'h0) begin
            tests_failed++; $display("FAIL reset_bus: we=%b sel=%h adr=%h dat=%h, want all 0", wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rsp: valid=%b err=%b dat=%h, want 0 0 0", rsp_valid, rsp_err, rsp_dat);
        end
        wb_rst_ni = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if (wbm_cyc_o !== 1'b1 || cmd_ready !== 1'b0 || wbm_adr_o !== 32'h3000_0008) begin
            tests_failed++; $display("FAIL reset_first_accept: cyc=%b ready=%b adr=%h, want 1 0 30000008", wbm_cyc_o, cmd_ready, wbm_adr_o);
        end
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_0001;
        tick();
        wbm_ack_i = 1'b0; rsp_ready = 1'b1;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE_0001) begin
            tests_failed++; $display("FAIL reset_first_rsp: valid=%b dat=%h, want 1 cafe0001", rsp_valid, rsp_dat);
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_write;
        issue(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hF ||
            wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'h0000_00A5) begin
            tests_failed++; $display("FAIL write_launch: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, want 1 1 1 f 30000004 000000a5",
                wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
        end
        tick();
        tests_run++;
        if (wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL write_hold: cyc=%b rsp_valid=%b, want 1 0", wbm_cyc_o, rsp_valid);
        end
        tick();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF; rsp_ready = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        tests_run++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'h0 ||
            rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin
            tests_failed++; $display("FAIL write_rsp: cyc=%b we=%b sel=%h valid=%b dat=%h err=%b, want 0 0 0 1 0 0",
                wbm_cyc_o, wbm_we_o, wbm_sel_o, rsp_valid, rsp_dat, rsp_err);
        end
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'h0000_00A5) begin
            tests_failed++; $display("FAIL write_done: valid=%b ready=%b adr=%h dat=%h, want 0 1 30000004 000000a5",
                rsp_valid, cmd_ready, wbm_adr_o, wbm_dat_o);
        end
    endtask

    task automatic test_read_backpressure;
        int bad = 0;
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678; rsp_ready = 1'b0;
        tick();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'h1234_5678 || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) bad++;
            if (i < 4) tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL read_hold: %0d bad cycles, dat=%h, want 0 bad, dat 12345678", bad, rsp_dat);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++; $display("FAIL read_release: valid=%b ready=%b, want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        int issued = 0, got = 0, launches = 0, bad = 0, cyc_n = 0;
        logic accept, prev_cyc;
        prev_cyc = 1'b0;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        for (int cyc_i = 0; cyc_i < 120; cyc_i++) begin
            accept = cmd_valid & cmd_ready;
            tick();
            if (accept) begin
                issued++;
                if (issued < 8) cmd_adr = 32'h3000_0100 + 32'(issued * 4);
                else cmd_valid = 1'b0;
            end
            if (wbm_cyc_o && !prev_cyc) launches++;
            prev_cyc = wbm_cyc_o;
            if (rsp_valid) begin
                if (wbm_cyc_o !== 1'b0 || rsp_dat !== ((32'h3000_0100 + 32'(got * 4)) ^ 32'h5A5A_0000)) bad++;
                got++;
            end
            if (wbm_cyc_o) begin
                wbm_ack_i = 1'b1; wbm_dat_i = wbm_adr_o ^ 32'h5A5A_0000;
            end else begin
                cyc_n++;
                wbm_ack_i = cyc_n[0]; wbm_dat_i = 32'hDEAD_BEEF;
            end
        end
        wbm_ack_i = 1'b0; rsp_ready = 1'b0;
        tests_run++;
        if (got != 8 || bad != 0) begin
            tests_failed++; $display("FAIL b2b_rsp: got %0d responses with %0d bad, want 8 with 0 bad", got, bad);
        end
        tests_run++;
        if (launches != 8) begin
            tests_failed++; $display("FAIL b2b_launches: %0d cyc bursts, want 8", launches);
        end
    endtask

    task automatic test_timeout;
        int high;
`ifdef WBM_TIMEOUT_EN
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        high = 0;
        for (int i = 0; i < 40 && wbm_cyc_o; i++) begin
            high++;
            tick();
        end
        tests_run++;
        if (high != 16 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0) begin
            tests_failed++; $display("FAIL timeout_abort: cyc high %0d, valid=%b err=%b dat=%h, want 16 1 1 0", high, rsp_valid, rsp_err, rsp_dat);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        issue(1'b0, 32'h3000_0014, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
        tick();
        wbm_ack_i = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0BAD_F00D) begin
            tests_failed++; $display("FAIL timeout_ack_wins: valid=%b err=%b dat=%h, want 1 0 0badf00d", rsp_valid, rsp_err, rsp_dat);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`else
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        high = 0;
        for (int i = 0; i < 40; i++) begin
            if (wbm_cyc_o === 1'b1 && rsp_valid === 1'b0) high++;
            tick();
        end
        tests_run++;
        if (high != 40) begin
            tests_failed++; $display("FAIL no_timeout_wait: cyc held %0d of 40 cycles, want 40", high);
        end
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
        tick();
        wbm_ack_i = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0BAD_F00D) begin
            tests_failed++; $display("FAIL no_timeout_rsp: valid=%b err=%b dat=%h, want 1 0 0badf00d", rsp_valid, rsp_err, rsp_dat);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_transfer;
        int seen = 0;
        issue(1'b1, 32'h3000_0020, 32'h0000_0077, 4'h3);
        tick();
        cmd_valid = 1'b0;
        tick();
        #2 wb_rst_ni = 1'b0;
        #1;
        tests_run++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_async: cyc=%b stb=%b, want 0 0", wbm_cyc_o, wbm_stb_o);
        end
        wbm_ack_i = 1'b1; rsp_ready = 1'b0;
        tick();
        wbm_ack_i = 1'b0;
        wb_rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++; $display("FAIL midrst_quiet: %0d cycles with response/cyc/not-ready, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_mid_transfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
